// File: rtl/wd_channel_router_nxm_pkg.sv
// Shared definitions for the W-channel router: index widths, order-queue entry layout, defaults.
// Entry layout is {master, slave, len} with len in the least-significant bits.
package wd_channel_router_nxm_pkg;

   localparam int unsigned DEF_NUM_MASTERS = 2;
   localparam int unsigned DEF_NUM_SLAVES  = 2;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_QUEUE_DEPTH = 4;
   localparam int unsigned LEN_W           = 8;

   // A single port still needs a 1-bit index so every port has a legal width.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned entry_w(input int unsigned nm, input int unsigned ns);
      return idx_w(nm) + idx_w(ns) + LEN_W;
   endfunction

   function automatic int unsigned slave_lsb();
      return LEN_W;
   endfunction

   function automatic int unsigned master_lsb(input int unsigned ns);
      return LEN_W + idx_w(ns);
   endfunction

endpackage

// File: rtl/wd_order_fifo.sv
// Synchronous FIFO holding the AW-granted order entries; head is readable combinationally.
// A push while full is accepted only when a pop happens in the same cycle.
module wd_order_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;
   logic             w_wr;
   logic             w_rd;

   assign full  = (r_count == (PTR_W + 1)'(DEPTH));
   assign empty = (r_count == '0);
   assign w_rd  = pop && !empty;
   assign w_wr  = push && (!full || w_rd);
   assign rdata = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + {{PTR_W{1'b0}}, w_wr} - {{PTR_W{1'b0}}, w_rd};
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= wdata;
   end

endmodule

// File: rtl/wd_channel_router_nxm.sv
// Routes AXI W bursts from N masters to M slaves in AW-grant order, one burst at a time.
// Tracks beats against awlen, flags overflow/length errors, and reports each completed burst.
module wd_channel_router_nxm
   import wd_channel_router_nxm_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic                              aw_push,
   input  logic [idx_w(NUM_MASTERS)-1:0]     aw_master,
   input  logic [idx_w(NUM_SLAVES)-1:0]      aw_slave,
   input  logic [LEN_W-1:0]                  aw_len,
   input  logic [NUM_MASTERS*DATA_W-1:0]     s_wdata,
   input  logic [NUM_MASTERS*DATA_W/8-1:0]   s_wstrb,
   input  logic [NUM_MASTERS-1:0]            s_wlast,
   input  logic [NUM_MASTERS-1:0]            s_wvalid,
   output logic [NUM_MASTERS-1:0]            s_wready,
   output logic [NUM_SLAVES*DATA_W-1:0]      m_wdata,
   output logic [NUM_SLAVES*DATA_W/8-1:0]    m_wstrb,
   output logic [NUM_SLAVES-1:0]             m_wlast,
   output logic [NUM_SLAVES-1:0]             m_wvalid,
   input  logic [NUM_SLAVES-1:0]             m_wready,
   output logic                              queue_full,
   output logic                              queue_empty,
   output logic                              wd_done,
   output logic [idx_w(NUM_MASTERS)-1:0]     wd_master,
   output logic [idx_w(NUM_SLAVES)-1:0]      wd_slave,
   output logic                              ovf_err,
   output logic                              len_err
);

   localparam int unsigned MW = idx_w(NUM_MASTERS);
   localparam int unsigned SW = idx_w(NUM_SLAVES);
   localparam int unsigned SB = DATA_W / 8;
   localparam int unsigned EW = entry_w(NUM_MASTERS, NUM_SLAVES);

   logic [EW-1:0]    w_push_entry;
   logic [EW-1:0]    w_head;
   logic [MW-1:0]    w_hm;
   logic [SW-1:0]    w_hs;
   logic [LEN_W-1:0] w_hl;
   logic             w_full;
   logic             w_empty;
   logic             w_route_en;
   logic             w_beat;
   logic             w_last;
   logic             w_pop;

   logic [7:0]       r_beat_cnt;
   logic             r_gap;
   logic             r_wd_done;
   logic [MW-1:0]    r_wd_master;
   logic [SW-1:0]    r_wd_slave;
   logic             r_ovf_err;
   logic             r_len_err;

   assign w_push_entry = {aw_master, aw_slave, aw_len};
   assign w_hm         = w_head[master_lsb(NUM_SLAVES) +: MW];
   assign w_hs         = w_head[slave_lsb() +: SW];
   assign w_hl         = w_head[LEN_W-1:0];

   wd_order_fifo #(
      .WIDTH (EW),
      .DEPTH (QUEUE_DEPTH)
   ) u_order_fifo (
      .clk   (ACLK),
      .rst   (ARESET),
      .push  (aw_push),
      .pop   (w_pop),
      .wdata (w_push_entry),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   // The cycle right after a pop is held idle before the next entry routes.
   assign w_route_en = !w_empty && !r_gap;

   always_comb begin
      s_wready = '0;
      m_wvalid = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      m_wlast  = '0;
      w_beat   = 1'b0;
      w_last   = 1'b0;
      if (w_route_en) begin
         m_wvalid[w_hs]               = s_wvalid[w_hm];
         s_wready[w_hm]               = m_wready[w_hs];
         m_wdata[w_hs*DATA_W +: DATA_W] = s_wdata[w_hm*DATA_W +: DATA_W];
         m_wstrb[w_hs*SB +: SB]       = s_wstrb[w_hm*SB +: SB];
         m_wlast[w_hs]                = s_wlast[w_hm];
         w_beat                       = s_wvalid[w_hm] && m_wready[w_hs];
         w_last                       = s_wlast[w_hm];
      end
   end

   assign w_pop = w_beat && w_last;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_beat_cnt  <= '0;
         r_gap       <= 1'b0;
         r_wd_done   <= 1'b0;
         r_wd_master <= '0;
         r_wd_slave  <= '0;
         r_ovf_err   <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         r_gap     <= w_pop;
         r_wd_done <= w_pop;
         if (w_pop) begin
            r_beat_cnt  <= '0;
            r_wd_master <= w_hm;
            r_wd_slave  <= w_hs;
         end else if (w_beat && (r_beat_cnt != 8'hFF)) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end
         if (aw_push && w_full && !w_pop) r_ovf_err <= 1'b1;
         if (w_beat && (w_last ? (r_beat_cnt != w_hl) : (r_beat_cnt == w_hl))) r_len_err <= 1'b1;
      end
   end

   assign queue_full  = w_full;
   assign queue_empty = w_empty;
   assign wd_done     = r_wd_done;
   assign wd_master   = r_wd_master;
   assign wd_slave    = r_wd_slave;
   assign ovf_err     = r_ovf_err;
   assign len_err     = r_len_err;

endmodule

// File: tb/tb_wd_channel_router_nxm.sv
// Directed and randomized bench for wd_channel_router_nxm, checked against a queue-based model.
module tb_wd_channel_router_nxm;

   localparam int NM = 2;
   localparam int NS = 2;
   localparam int DW = 32;
   localparam int SBW = DW / 8;
   localparam int QD = 4;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic              aw_push;
   logic [0:0]        aw_master;
   logic [0:0]        aw_slave;
   logic [7:0]        aw_len;
   logic [NM*DW-1:0]  s_wdata;
   logic [NM*SBW-1:0] s_wstrb;
   logic [NM-1:0]     s_wlast;
   logic [NM-1:0]     s_wvalid;
   logic [NM-1:0]     s_wready;
   logic [NS*DW-1:0]  m_wdata;
   logic [NS*SBW-1:0] m_wstrb;
   logic [NS-1:0]     m_wlast;
   logic [NS-1:0]     m_wvalid;
   logic [NS-1:0]     m_wready;
   logic              queue_full;
   logic              queue_empty;
   logic              wd_done;
   logic [0:0]        wd_master;
   logic [0:0]        wd_slave;
   logic              ovf_err;
   logic              len_err;

   wd_channel_router_nxm #(
      .NUM_MASTERS (NM),
      .NUM_SLAVES  (NS),
      .DATA_W      (DW),
      .QUEUE_DEPTH (QD)
   ) dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .aw_push     (aw_push),
      .aw_master   (aw_master),
      .aw_slave    (aw_slave),
      .aw_len      (aw_len),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_wlast     (s_wlast),
      .s_wvalid    (s_wvalid),
      .s_wready    (s_wready),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_wlast     (m_wlast),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .queue_full  (queue_full),
      .queue_empty (queue_empty),
      .wd_done     (wd_done),
      .wd_master   (wd_master),
      .wd_slave    (wd_slave),
      .ovf_err     (ovf_err),
      .len_err     (len_err)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      int m;
      int s;
      int len;
   } ent_t;

   ent_t mq[$];
   bit   mgap;
   int   mcnt;
   bit   mdone;
   int   mdm;
   int   mds;
   bit   movf;
   bit   mlen;
   int   n_tests;
   int   n_fail;
   int   dut_done_cnt;
   int   model_beats;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mgap  = 0;
      mcnt  = 0;
      mdone = 0;
      mdm   = 0;
      mds   = 0;
      movf  = 0;
      mlen  = 0;
   endtask

   task automatic check_all();
      logic [NS-1:0]     e_mv;
      logic [NM-1:0]     e_sr;
      logic [NS*DW-1:0]  e_md;
      logic [NS*SBW-1:0] e_ms;
      logic [NS-1:0]     e_ml;
      ent_t              h;
      e_mv = '0;
      e_sr = '0;
      e_md = '0;
      e_ms = '0;
      e_ml = '0;
      if (mq.size() > 0 && !mgap) begin
         h = mq[0];
         e_mv[h.s]             = s_wvalid[h.m];
         e_sr[h.m]             = m_wready[h.s];
         e_md[h.s*DW +: DW]    = s_wdata[h.m*DW +: DW];
         e_ms[h.s*SBW +: SBW]  = s_wstrb[h.m*SBW +: SBW];
         e_ml[h.s]             = s_wlast[h.m];
      end
      chk("m_wvalid", m_wvalid, e_mv);
      chk("s_wready", s_wready, e_sr);
      chk("m_wdata", m_wdata, e_md);
      chk("m_wstrb", m_wstrb, e_ms);
      chk("m_wlast", m_wlast, e_ml);
      chk("queue_full", queue_full, mq.size() == QD);
      chk("queue_empty", queue_empty, mq.size() == 0);
      chk("wd_done", wd_done, mdone);
      chk("wd_master", wd_master, mdm[0]);
      chk("wd_slave", wd_slave, mds[0]);
      chk("ovf_err", ovf_err, movf);
      chk("len_err", len_err, mlen);
      if (wd_done === 1'b1) dut_done_cnt++;
   endtask

   task automatic model_step();
      ent_t h;
      bit   beat;
      bit   pop;
      beat = 0;
      pop  = 0;
      if (ARESET) begin
         model_reset();
      end else begin
         if (mq.size() > 0 && !mgap) begin
            h    = mq[0];
            beat = s_wvalid[h.m] && m_wready[h.s];
            pop  = beat && s_wlast[h.m];
            if (beat) begin
               model_beats++;
               if (s_wlast[h.m] ? (mcnt != h.len) : (mcnt == h.len)) mlen = 1;
               mcnt = pop ? 0 : ((mcnt == 255) ? 255 : mcnt + 1);
            end
         end
         mdone = pop;
         if (pop) begin
            mdm = h.m;
            mds = h.s;
            void'(mq.pop_front());
         end
         if (aw_push) begin
            if (mq.size() < QD) mq.push_back('{m: int'(aw_master), s: int'(aw_slave),
                                               len: int'(aw_len)});
            else movf = 1;
         end
         mgap = pop;
      end
   endtask

   task automatic cycle();
      @(negedge ACLK);
      check_all();
      @(posedge ACLK);
      model_step();
      #1;
      aw_push = 1'b0;
   endtask

   task automatic push_ent(input int m, input int s, input int len);
      aw_push   = 1'b1;
      aw_master = 1'(m);
      aw_slave  = 1'(s);
      aw_len    = 8'(len);
   endtask

   task automatic set_m(input int m, input bit v, input logic [31:0] d, input bit last);
      s_wvalid[m]             = v;
      s_wdata[m*DW +: DW]     = d;
      s_wstrb[m*SBW +: SBW]   = 4'hF;
      s_wlast[m]              = last;
   endtask

   initial begin
      int done0;
      int beats0;
      n_tests      = 0;
      n_fail       = 0;
      dut_done_cnt = 0;
      model_beats  = 0;
      ARESET   = 1'b1;
      aw_push  = 1'b0;
      aw_master = '0;
      aw_slave = '0;
      aw_len   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      s_wlast  = '0;
      s_wvalid = '0;
      m_wready = '1;
      @(posedge ACLK);
      @(posedge ACLK);
      #1;
      model_reset();
      cycle();
      ARESET = 1'b0;
      cycle();

      // Single beat m0 -> s1
      push_ent(0, 1, 0);
      cycle();
      set_m(0, 1, 32'hDEADBEEF, 1);
      cycle();
      set_m(0, 0, 32'h0, 0);
      cycle();
      chk("req035_done_master", wd_master, 1'b0);
      chk("req035_done_slave", wd_slave, 1'b1);
      cycle();

      // Four-beat burst m1 -> s0
      push_ent(1, 0, 3);
      cycle();
      for (int i = 0; i < 4; i++) begin
         set_m(1, 1, 32'h1000 + 32'(i), i == 3);
         cycle();
      end
      set_m(1, 0, 32'h0, 0);
      cycle();
      chk("req036_len_err", len_err, 1'b0);

      // Early wvalid from a master whose entry is not yet at the head
      push_ent(0, 0, 1);
      cycle();
      push_ent(1, 1, 0);
      set_m(1, 1, 32'hAAAA5555, 1);
      cycle();
      chk("req037_early_ready", s_wready[1], 1'b0);
      set_m(0, 1, 32'h11, 0);
      cycle();
      set_m(0, 1, 32'h22, 1);
      cycle();
      set_m(0, 0, 32'h0, 0);
      cycle();
      cycle();
      set_m(1, 0, 32'h0, 0);
      cycle();

      // Overflow: five pushes into a 4-deep queue with no data moving
      for (int i = 0; i < 5; i++) begin
         push_ent(i % 2, (i / 2) % 2, 0);
         cycle();
      end
      chk("req038_full", queue_full, 1'b1);
      chk("req038_ovf", ovf_err, 1'b1);
      done0 = dut_done_cnt;
      set_m(0, 1, 32'h5A5A0000, 1);
      set_m(1, 1, 32'h5A5A0001, 1);
      for (int i = 0; i < 12; i++) cycle();
      set_m(0, 0, 32'h0, 0);
      set_m(1, 0, 32'h0, 0);
      cycle();
      chk("req038_bursts", dut_done_cnt - done0, 4);

      // Early wlast sets len_err but still completes the burst
      push_ent(0, 0, 3);
      cycle();
      set_m(0, 1, 32'h77, 0);
      cycle();
      set_m(0, 1, 32'h78, 1);
      cycle();
      set_m(0, 0, 32'h0, 0);
      chk("req039_done", wd_done, 1'b1);
      cycle();
      chk("req039_len_err", len_err, 1'b1);

      // Stall then reset mid-burst
      push_ent(1, 1, 7);
      cycle();
      set_m(1, 1, 32'h99, 0);
      cycle();
      m_wready = 2'b00;
      beats0 = model_beats;
      for (int i = 0; i < 3; i++) cycle();
      chk("req040_stall_beats", model_beats - beats0, 0);
      ARESET = 1'b1;
      cycle();
      ARESET   = 1'b0;
      m_wready = 2'b11;
      cycle();
      chk("req040_rst_valid", m_wvalid, 2'b00);
      chk("req040_rst_len_err", len_err, 1'b0);
      set_m(1, 0, 32'h0, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0)
            push_ent($urandom_range(0, NM - 1), $urandom_range(0, NS - 1), $urandom_range(0, 3));
         for (int m = 0; m < NM; m++)
            set_m(m, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2) == 0);
         m_wready = 2'($urandom);
         ARESET   = ($urandom_range(0, 199) == 0);
         cycle();
         ARESET = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
